// File: rtl/load_unit.sv
// ---------------------------------------------------------------------------
// load_unit
// Multi-cycle data-memory load sequencer. It accepts a byte-addressed load
// request, runs a req/ack read on the word-wide data memory port, then
// extracts and sign/zero-extends the addressed byte, half or word. The
// result is held on load_data, which feeds the memory-data input of the
// writeback select mux. Misaligned or reserved-size requests and unanswered
// memory reads end in a one-cycle error pulse, so the core never hangs.
//
// Ports:
//   clk        - the only clock; all state changes on the rising edge
//   reset      - synchronous, active-high
//   start      - load request, sampled only while idle
//   address    - byte address of the load
//   size       - 0 byte, 1 half, 2 word, 3 reserved (always errors)
//   sign_ext   - 1 sign-extend, 0 zero-extend (byte/half only)
//   mem_req    - memory read request, held until mem_ack
//   mem_addr   - word-aligned read address
//   mem_ack    - memory response valid
//   mem_rdata  - memory read word
//   load_data  - extracted, extended load result
//   done       - one-cycle pulse, load_data updated
//   error      - one-cycle pulse, misaligned / reserved size / timeout
//   busy       - high in every state except idle
// ---------------------------------------------------------------------------
module load_unit #(
    parameter int word_size      = 32,
    parameter int addr_size      = 32,
    parameter int timeout_cycles = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addr_size-1:0] address,
    input  logic [1:0]           size,
    input  logic                 sign_ext,
    output logic                 mem_req,
    output logic [addr_size-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [word_size-1:0] mem_rdata,
    output logic [word_size-1:0] load_data,
    output logic                 done,
    output logic                 error,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Counter limit; the legal timeout range fits in 8 bits.
    localparam logic [7:0] timeout_lim = 8'(timeout_cycles);

    // Request legality: bytes anywhere, halves on even, words on 4-byte
    // boundaries; the reserved size never passes.
    function automatic logic is_legal(input logic [1:0] off, input logic [1:0] sz);
        logic ok;
        ok = 1'b0;
        case (sz)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~off[0];
            2'd2:    ok = (off == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian lane extraction followed by sign or zero extension.
    function automatic logic [word_size-1:0] extract_lane(
        input logic [word_size-1:0] word,
        input logic [1:0]           off,
        input logic [1:0]           sz,
        input logic                 sx
    );
        logic [7:0]           byte_v;
        logic [15:0]          half_v;
        logic [word_size-1:0] res;
        byte_v = 8'h00;
        half_v = 16'h0000;
        res    = {word_size{1'b0}};
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = 8'h00;
        endcase
        if (off[1]) begin
            half_v = word[31:16];
        end else begin
            half_v = word[15:0];
        end
        case (sz)
            2'd0:    res = {{(word_size-8){sx & byte_v[7]}}, byte_v};
            2'd1:    res = {{(word_size-16){sx & half_v[15]}}, half_v};
            default: res = word;  // word loads ignore sign_ext
        endcase
        return res;
    endfunction

    state_t               state_r, state_next_s;
    logic [7:0]           cnt_r, cnt_next_s, cnt_inc_s;
    logic [1:0]           off_r, off_next_s;
    logic [1:0]           size_r, size_next_s;
    logic                 sext_r, sext_next_s;
    logic                 mem_req_r, mem_req_next_s;
    logic [addr_size-1:0] mem_addr_r, mem_addr_next_s;
    logic [word_size-1:0] load_data_r, load_data_next_s;
    logic                 done_r, done_next_s;
    logic                 error_r, error_next_s;
    logic                 busy_r, busy_next_s;

    assign cnt_inc_s = cnt_r + 8'd1;

    // Next-state and next-output logic; every output is computed here and
    // registered below so the ports come straight from flops.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        off_next_s       = off_r;
        size_next_s      = size_r;
        sext_next_s      = sext_r;
        mem_req_next_s   = mem_req_r;
        mem_addr_next_s  = mem_addr_r;
        load_data_next_s = load_data_r;
        done_next_s      = 1'b0;
        error_next_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (is_legal(address[1:0], size)) begin
                        state_next_s    = ST_WAIT;
                        mem_req_next_s  = 1'b1;
                        mem_addr_next_s = {address[addr_size-1:2], 2'b00};
                        cnt_next_s      = 8'd0;
                        off_next_s      = address[1:0];
                        size_next_s     = size;
                        sext_next_s     = sign_ext;
                    end else begin
                        // Rejected before any memory traffic.
                        state_next_s = ST_ERR;
                        error_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    // An ack on the last allowed cycle still wins over timeout.
                    state_next_s     = ST_DONE;
                    load_data_next_s = extract_lane(mem_rdata, off_r, size_r, sext_r);
                    done_next_s      = 1'b1;
                    mem_req_next_s   = 1'b0;
                end else if (cnt_inc_s >= timeout_lim) begin
                    state_next_s   = ST_ERR;
                    error_next_s   = 1'b1;
                    mem_req_next_s = 1'b0;
                    cnt_next_s     = cnt_inc_s;
                end else begin
                    cnt_next_s = cnt_inc_s;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            ST_ERR: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s   = ST_IDLE;
                mem_req_next_s = 1'b0;
            end
        endcase
        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            off_r       <= 2'd0;
            size_r      <= 2'd0;
            sext_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= {addr_size{1'b0}};
            load_data_r <= {word_size{1'b0}};
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            off_r       <= off_next_s;
            size_r      <= size_next_s;
            sext_r      <= sext_next_s;
            mem_req_r   <= mem_req_next_s;
            mem_addr_r  <= mem_addr_next_s;
            load_data_r <= load_data_next_s;
            done_r      <= done_next_s;
            error_r     <= error_next_s;
            busy_r      <= busy_next_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign load_data = load_data_r;
    assign done      = done_r;
    assign error     = error_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_load_unit.sv
// ---------------------------------------------------------------------------
// tb_load_unit
// Self-checking bench for load_unit: a table of directed load vectors with
// hand-computed results and latencies, plus hand-written sequences for reset
// values, a stray ack while idle and a reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_load_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] address;
    logic [1:0]  size;
    logic        sign_ext;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        error;
    logic        busy;

    int n_checks;
    int n_fail;

    load_unit #(
        .word_size      (32),
        .addr_size      (32),
        .timeout_cycles (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .address   (address),
        .size      (size),
        .sign_ext  (sign_ext),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .load_data (load_data),
        .done      (done),
        .error     (error),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One load vector. ack_wait is the number of WAIT cycles without ack
    // before the acked cycle (-1: never ack). exp_lat counts cycles from the
    // start cycle to the done/error pulse.
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] rdata;
        int          ack_wait;
        logic        extra_start;
        logic        exp_done;
        logic [31:0] exp_data;
        int          exp_lat;
        logic        exp_req;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        int          pulse_cyc;
        logic        got_done;
        logic        got_err;
        logic        req_seen;
        logic [31:0] req_addr;

        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        address   = 32'h0000_0000;
        size      = 2'd0;
        sign_ext  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;

        // addr, sz, sx, rdata, ack_wait, extra_start, exp_done, exp_data, exp_lat, exp_req
        vecs[0]  = '{32'h0000_0100, 2'd2, 1'b0, 32'hDEAD_BEEF, 0,  1'b0, 1'b1, 32'hDEAD_BEEF, 2,  1'b1};
        vecs[1]  = '{32'h0000_0103, 2'd0, 1'b1, 32'h80FF_1234, 0,  1'b0, 1'b1, 32'hFFFF_FF80, 2,  1'b1};
        vecs[2]  = '{32'h0000_0103, 2'd0, 1'b0, 32'h80FF_1234, 2,  1'b0, 1'b1, 32'h0000_0080, 4,  1'b1};
        vecs[3]  = '{32'h0000_0102, 2'd1, 1'b1, 32'h8001_7FFF, 1,  1'b0, 1'b1, 32'hFFFF_8001, 3,  1'b1};
        vecs[4]  = '{32'h0000_0101, 2'd2, 1'b0, 32'h1111_1111, 0,  1'b0, 1'b0, 32'hFFFF_8001, 1,  1'b0};
        vecs[5]  = '{32'h0000_0100, 2'd3, 1'b0, 32'h2222_2222, 0,  1'b0, 1'b0, 32'hFFFF_8001, 1,  1'b0};
        vecs[6]  = '{32'h0000_0103, 2'd1, 1'b1, 32'h3333_3333, 0,  1'b0, 1'b0, 32'hFFFF_8001, 1,  1'b0};
        vecs[7]  = '{32'h0000_0200, 2'd2, 1'b0, 32'h4444_4444, -1, 1'b0, 1'b0, 32'hFFFF_8001, 16, 1'b1};
        vecs[8]  = '{32'h0000_0204, 2'd2, 1'b0, 32'h1234_5678, 14, 1'b0, 1'b1, 32'h1234_5678, 16, 1'b1};
        vecs[9]  = '{32'h0000_0101, 2'd0, 1'b0, 32'h0000_AB00, 3,  1'b1, 1'b1, 32'h0000_00AB, 5,  1'b1};
        vecs[10] = '{32'h0000_0010, 2'd1, 1'b0, 32'h1234_F00D, 0,  1'b0, 1'b1, 32'h0000_F00D, 2,  1'b1};
        vecs[11] = '{32'h0000_0022, 2'd0, 1'b1, 32'h007F_0000, 0,  1'b0, 1'b1, 32'h0000_007F, 2,  1'b1};
        vecs[12] = '{32'h0000_0300, 2'd2, 1'b1, 32'h8000_0001, 1,  1'b0, 1'b1, 32'h8000_0001, 3,  1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        check("reset mem_req",   {31'd0, mem_req}, 32'd0);
        check("reset mem_addr",  mem_addr,         32'd0);
        check("reset load_data", load_data,        32'd0);
        check("reset done",      {31'd0, done},    32'd0);
        check("reset error",     {31'd0, error},   32'd0);
        check("reset busy",      {31'd0, busy},    32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven loads
        for (int i = 0; i < 13; i++) begin
            start     = 1'b1;
            address   = vecs[i].addr;
            size      = vecs[i].sz;
            sign_ext  = vecs[i].sx;
            mem_rdata = 32'h5A5A_5A5A;
            pulse_cyc = 0;
            got_done  = 1'b0;
            got_err   = 1'b0;
            req_seen  = 1'b0;
            req_addr  = 32'h0000_0000;
            for (int c = 1; c <= 40 && pulse_cyc == 0; c++) begin
                @(negedge clk);
                start   = vecs[i].extra_start;
                mem_ack = 1'b0;
                if (done || error) begin
                    pulse_cyc = c;
                    got_done  = done;
                    got_err   = error;
                end else begin
                    if (mem_req && !req_seen) begin
                        req_seen = 1'b1;
                        req_addr = mem_addr;
                    end
                    if (vecs[i].ack_wait >= 0 && c == vecs[i].ack_wait + 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = vecs[i].rdata;
                    end
                end
            end
            start   = 1'b0;
            mem_ack = 1'b0;
            check($sformatf("v%0d done", i),      {31'd0, got_done}, {31'd0, vecs[i].exp_done});
            check($sformatf("v%0d error", i),     {31'd0, got_err},  {31'd0, ~vecs[i].exp_done});
            check($sformatf("v%0d latency", i),   pulse_cyc,         vecs[i].exp_lat);
            check($sformatf("v%0d load_data", i), load_data,         vecs[i].exp_data);
            check($sformatf("v%0d mem_req", i),   {31'd0, req_seen}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) begin
                check($sformatf("v%0d mem_addr", i), req_addr, vecs[i].addr & 32'hFFFF_FFFC);
            end
            @(negedge clk);
            check($sformatf("v%0d pulse width", i), {30'd0, done, error}, 32'd0);
            check($sformatf("v%0d back idle", i),   {31'd0, busy},        32'd0);
        end

        // Stray ack while idle: no done, no request
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stray ack done",  {31'd0, done},    32'd0);
            check("stray ack busy",  {31'd0, busy},    32'd0);
            check("stray ack req",   {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;
        check("stray ack load_data", load_data, 32'h8000_0001);

        // Reset during WAIT: back to reset values, no pulse afterwards
        start    = 1'b1;
        address  = 32'h0000_0400;
        size     = 2'd2;
        sign_ext = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("rst wait mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst mid mem_req",   {31'd0, mem_req}, 32'd0);
        check("rst mid mem_addr",  mem_addr,         32'd0);
        check("rst mid load_data", load_data,        32'd0);
        check("rst mid busy",      {31'd0, busy},    32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("rst after pulse", {30'd0, done, error}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_unit.md
# load_unit

Multi-cycle data-memory load sequencer feeding the writeback source mux of the basic CPU. It accepts a load request (byte address, size, signedness) and runs a req/ack read on the word-wide data-memory port. It then extracts and extends the addressed byte, half or word, and holds the result on `load_data`, which drives data input 1 (memory data) of the 4:1 writeback select mux. Misaligned requests and unanswered memory reads are reported as errors instead of hanging the core.

## Interface

Parameters:
- `word_size`, 32: data width; fixed at 32, since lane extraction assumes 4 byte lanes.
- `addr_size`, 32: byte-address width.
- `timeout_cycles`, 15: maximum WAIT cycles without `mem_ack` before error; legal range 1–255.

Ports:
- `clk`  input  1  — the only clock; all state changes on the rising edge.
- `reset`  input  1  — synchronous, active-high.
- `start`  input  1  — load request; sampled only in IDLE.
- `address`  input  `addr_size`  — byte address of the load.
- `size`  input  2  — 0 = byte, 1 = half, 2 = word, 3 = reserved (always errors).
- `sign_ext`  input  1  — 1 = sign-extend, 0 = zero-extend (byte/half only).
- `mem_req`  output  1  — memory read request.
- `mem_addr`  output  `addr_size`  — word-aligned address (`address` with bits [1:0] cleared).
- `mem_ack`  input  1  — memory response valid.
- `mem_rdata`  input  `word_size`  — memory read word.
- `load_data`  output  `word_size`  — extracted, extended result; to writeback mux input 1.
- `done`  output  1  — one-cycle pulse: `load_data` updated.
- `error`  output  1  — one-cycle pulse: misaligned, reserved size, or timeout.
- `busy`  output  1  — high in every state except IDLE.

## Operation

States are IDLE, WAIT, DONE and ERR. All outputs are registered.

IDLE:
- `start=1` with a legal, aligned request: latch `address[1:0]`, `size` and `sign_ext`; drive `mem_addr`; clear the timeout counter; go to WAIT.
- Legal alignment: byte is any address; half needs `address[0]=0`; word needs `address[1:0]=0`.
- Misaligned request or `size=3`: go to ERR. No memory request is issued.

WAIT:
- `mem_req=1` throughout; `mem_addr` is stable.
- `mem_ack=1`: capture the extracted `mem_rdata` into `load_data`; go to DONE.
- `mem_ack=0`: increment the counter. If the counter reaches `timeout_cycles`, go to ERR.

DONE: `done=1` for one cycle, then IDLE.

ERR: `error=1` for one cycle, `load_data` unchanged, then IDLE.

Extraction (little-endian):
- Byte: lane = offset, bits [8·off+7 : 8·off].
- Half: lane = offset[1], bits [16·off[1]+15 : 16·off[1]].
- Word: all 32 bits; `sign_ext` is ignored.
- Extension fills the upper bits with the lane MSB when `sign_ext=1`, otherwise with 0.

## Timing

- Reset values: state IDLE, `mem_req=0`, `mem_addr=0`, `load_data=0`, `done=0`, `error=0`, `busy=0`, counter 0.
- Start → request: `start` sampled at edge N gives `mem_req=1` and `busy=1` from cycle N+1.
- Request → done: `mem_ack` sampled high at edge M gives `done=1` and the new `load_data` in cycle M+1. `mem_req` drops in the same cycle.
- Minimum latency: 2 cycles from `start` to `done`.
- Handshake: `mem_req` stays high until `mem_ack` is seen. `mem_ack` while `mem_req=0` (IDLE/DONE/ERR) is ignored.
- Timeout: ERR is entered after exactly `timeout_cycles` WAIT cycles with no ack. If `mem_ack` arrives on the final allowed cycle, the ack wins and the load completes.
- Misalignment: error pulse in cycle N+1 with `mem_req` never asserted.
- `start` while `busy=1` is ignored; it is not queued.
- A new `start` is first accepted in the cycle after DONE/ERR, when the block is back in IDLE.
- `load_data` is stable between `done` pulses.
- `reset` mid-operation takes effect at the next edge: return to IDLE, drop `mem_req`, restore all outputs to their reset values. No `done` or `error` is emitted for the aborted load.

## Test plan

- **Word load:** `start`, address 0x100, size 2, ack in the first WAIT cycle with rdata 0xDEADBEEF → `mem_addr=0x100`, `done` 2 cycles after start, `load_data=0xDEADBEEF`.
- **Byte loads:** address 0x103, size 0, rdata 0x80FF_1234.
  - `sign_ext=1` → `load_data=0xFFFFFF80`.
  - `sign_ext=0` → `load_data=0x00000080`.
- **Half load:** address 0x102, size 1, `sign_ext=1`, rdata 0x8001_7FFF → `load_data=0xFFFF8001`.
- **Misalignment:** word load at 0x101, or size 3 → `error` pulse next cycle, `mem_req` never high, `load_data` holds its prior value.
- **Timeout:** `timeout_cycles=15`, no ack → `error` after 15 WAIT cycles.
  - Repeat with ack on WAIT cycle 15 → `done` instead, no `error`.
- **Robustness:**
  - `start` pulses during WAIT are ignored, giving exactly one `done`.
  - `reset` asserted in WAIT → next cycle IDLE, `mem_req=0`, `load_data=0`, no pulse.
  - A stray `mem_ack` in IDLE produces no `done`.
